// File: rtl/ws2812_ctrl_if.sv
// Picosoc iomem bus bundle between the CPU side (master) and ws2812_ctrl (slave).
// Signals: iomem_valid/iomem_wstrb/iomem_addr/iomem_wdata driven by the master;
// iomem_ready/iomem_rdata returned by the slave.
interface ws2812_ctrl_if;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;

  modport master (
    output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
    input  iomem_ready, iomem_rdata
  );

  modport slave (
    input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
    output iomem_ready, iomem_rdata
  );
endinterface

// File: rtl/ws2812_ctrl.sv
// ws2812_ctrl: iomem-mapped front end for the ws2812 driver's register file.
// Arbitrates the driver write port between CPU PIXEL writes and a fill engine
// and applies a global brightness scale to every pixel sent to the driver.
// Ports:
//   clk, reset         - system clock, synchronous active-high reset
//   bus (slave)        - iomem valid/ready/wstrb/addr/wdata/rdata
//   ws_write           - single-cycle write strobe to the driver
//   ws_led_num         - LED index to the driver
//   ws_rgb_data        - brightness-scaled GRB word to the driver
module ws2812_ctrl #(
  parameter int unsigned NUM_LEDS  = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0300_0000
) (
  input  logic          clk,
  input  logic          reset,
  ws2812_ctrl_if.slave  bus,
  output logic          ws_write,
  output logic [7:0]    ws_led_num,
  output logic [23:0]   ws_rgb_data
);

  localparam int unsigned IDX_W   = 9;
  localparam int unsigned RGB_W   = 24;
  localparam int unsigned DATA_W  = 32;
  localparam logic [IDX_W-1:0] LED_COUNT = IDX_W'(NUM_LEDS);

  localparam logic [3:0] OFF_PIXEL  = 4'h0;
  localparam logic [3:0] OFF_FILL   = 4'h4;
  localparam logic [3:0] OFF_STATUS = 4'h8;
  localparam logic [3:0] OFF_BRIGHT = 4'hC;

  typedef enum logic {ST_IDLE, ST_FILL} state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    fill_idx_q, fill_idx_d;
  logic [RGB_W-1:0]    fill_rgb_q, fill_rgb_d;
  logic [7:0]          bright_q, bright_d;
  logic                ready_q, ready_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                ws_write_q, ws_write_d;
  logic [7:0]          ws_led_num_q, ws_led_num_d;
  logic [RGB_W-1:0]    ws_rgb_q, ws_rgb_d;

  logic                sel;
  logic                accept;
  logic                is_write;
  logic [3:0]          offset;
  logic [IDX_W-1:0]    pixel_idx;
  logic                pixel_go;
  logic                fill_start;
  logic                busy;

  // One channel: (c * (b + 1)) >> 8; b = 255 is identity, b = 0 is black.
  function automatic logic [7:0] scale_chan(input logic [7:0] c, input logic [7:0] b);
    logic [16:0] prod;
    prod = 17'(c) * 17'({1'b0, b} + 9'd1);
    return 8'(prod >> 8);
  endfunction

  function automatic logic [RGB_W-1:0] scale_rgb(input logic [RGB_W-1:0] c, input logic [7:0] b);
    return {scale_chan(c[23:16], b), scale_chan(c[15:8], b), scale_chan(c[7:0], b)};
  endfunction

  // Request decode; !ready_q blocks re-accepting the request being acked.
  always_comb begin
    sel        = (bus.iomem_addr[31:4] == BASE_ADDR[31:4]);
    accept     = bus.iomem_valid && sel && !ready_q;
    is_write   = |bus.iomem_wstrb;
    offset     = bus.iomem_addr[3:0];
    pixel_idx  = {1'b0, bus.iomem_wdata[31:24]};
    pixel_go   = accept && is_write && (offset == OFF_PIXEL) && (pixel_idx < LED_COUNT);
    fill_start = accept && is_write && (offset == OFF_FILL);
    busy       = (state_q == ST_FILL);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      fill_idx_q   <= '0;
      fill_rgb_q   <= '0;
      bright_q     <= 8'hFF;
      ready_q      <= 1'b0;
      rdata_q      <= '0;
      ws_write_q   <= 1'b0;
      ws_led_num_q <= '0;
      ws_rgb_q     <= '0;
    end else begin
      state_q      <= state_d;
      fill_idx_q   <= fill_idx_d;
      fill_rgb_q   <= fill_rgb_d;
      bright_q     <= bright_d;
      ready_q      <= ready_d;
      rdata_q      <= rdata_d;
      ws_write_q   <= ws_write_d;
      ws_led_num_q <= ws_led_num_d;
      ws_rgb_q     <= ws_rgb_d;
    end
  end

  // Next-state: register file, fill FSM and driver-port arbitration.
  always_comb begin
    state_d      = state_q;
    fill_idx_d   = fill_idx_q;
    fill_rgb_d   = fill_rgb_q;
    bright_d     = bright_q;
    ready_d      = accept;
    rdata_d      = '0;
    ws_write_d   = 1'b0;
    ws_led_num_d = ws_led_num_q;
    ws_rgb_d     = ws_rgb_q;

    if (accept) begin
      if (is_write) begin
        if (offset == OFF_BRIGHT) begin
          bright_d = bus.iomem_wdata[7:0];
        end
      end else begin
        case (offset)
          OFF_STATUS: rdata_d = {23'b0, busy, fill_idx_q[7:0]};
          OFF_BRIGHT: rdata_d = {24'b0, bright_q};
          default:    rdata_d = '0;
        endcase
      end
    end

    if (state_q == ST_IDLE) begin
      if (fill_start) begin
        state_d    = ST_FILL;
        fill_idx_d = '0;
        fill_rgb_d = bus.iomem_wdata[23:0];
      end
    end else begin
      if (fill_start) begin
        // Restart in place: new colour, index back to 0, stay in FILL.
        fill_idx_d = '0;
        fill_rgb_d = bus.iomem_wdata[23:0];
      end else if (fill_idx_q == LED_COUNT) begin
        // Last pixel went out on the previous cycle.
        state_d = ST_IDLE;
      end else if (!pixel_go) begin
        ws_write_d   = 1'b1;
        ws_led_num_d = fill_idx_q[7:0];
        ws_rgb_d     = scale_rgb(fill_rgb_q, bright_q);
        fill_idx_d   = fill_idx_q + 9'd1;
      end
    end

    // CPU pixel owns the driver port for its cycle; the fill slot above is skipped.
    if (pixel_go) begin
      ws_write_d   = 1'b1;
      ws_led_num_d = bus.iomem_wdata[31:24];
      ws_rgb_d     = scale_rgb(bus.iomem_wdata[23:0], bright_q);
    end
  end

  assign bus.iomem_ready = ready_q;
  assign bus.iomem_rdata = rdata_q;
  assign ws_write        = ws_write_q;
  assign ws_led_num      = ws_led_num_q;
  assign ws_rgb_data     = ws_rgb_q;

endmodule

// File: tb/tb_ws2812_ctrl.sv
// Self-checking bench for ws2812_ctrl: bus transactions against a timestamped
// model of the expected driver write sequence.
module tb_ws2812_ctrl;
  localparam int unsigned NUM_LEDS = 8;
  localparam logic [31:0] A_PIXEL  = 32'h0300_0000;
  localparam logic [31:0] A_FILL   = 32'h0300_0004;
  localparam logic [31:0] A_STATUS = 32'h0300_0008;
  localparam logic [31:0] A_BRIGHT = 32'h0300_000C;

  logic        clk = 1'b0;
  logic        reset;
  logic        ws_write;
  logic [7:0]  ws_led_num;
  logic [23:0] ws_rgb_data;

  ws2812_ctrl_if bus();

  ws2812_ctrl #(.NUM_LEDS(NUM_LEDS), .BASE_ADDR(32'h0300_0000)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .ws_write    (ws_write),
    .ws_led_num  (ws_led_num),
    .ws_rgb_data (ws_rgb_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          t;
    logic [7:0]  idx;
    logic [23:0] rgb;
  } ev_t;

  ev_t obs[$];
  ev_t exp_q[$];

  always @(negedge clk) begin
    ev_t e;
    if (ws_write === 1'b1) begin
      e.t = cyc; e.idx = ws_led_num; e.rgb = ws_rgb_data;
      obs.push_back(e);
    end
  end

  int checks = 0;
  int errors = 0;
  int bright_m = 255;

  function automatic logic [23:0] scale_ref(input logic [23:0] c, input int b);
    int r, g, bl;
    g  = (int'(c[23:16]) * (b + 1)) / 256;
    r  = (int'(c[15:8])  * (b + 1)) / 256;
    bl = (int'(c[7:0])   * (b + 1)) / 256;
    return {8'(g), 8'(r), 8'(bl)};
  endfunction

  function automatic ev_t mk_ev(input int t, input int idx, input logic [23:0] rgb);
    ev_t e;
    e.t = t; e.idx = 8'(idx); e.rgb = rgb;
    return e;
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Called #1 after an edge; returns #1 after the accept edge (acc = its stamp).
  task automatic bus_xfer(input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, output logic [31:0] rdata,
                          output int acc);
    bit got;
    got = 0; acc = -1; rdata = '0;
    bus.iomem_valid = 1'b1; bus.iomem_addr = addr;
    bus.iomem_wdata = wdata; bus.iomem_wstrb = wstrb;
    for (int i = 0; i < 4 && !got; i++) begin
      @(posedge clk); #1;
      if (bus.iomem_ready === 1'b1) begin
        got = 1; acc = cyc; rdata = bus.iomem_rdata;
      end
    end
    bus.iomem_valid = 1'b0; bus.iomem_wstrb = 4'h0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL bus_ack addr=%h: iomem_ready=0 after 4 cycles, required 1", addr);
    end
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] wdata, output int acc);
    logic [31:0] unused_rd;
    bus_xfer(addr, wdata, 4'hF, unused_rd, acc);
  endtask

  task automatic rd(input logic [31:0] addr, output logic [31:0] data);
    int acc;
    bus_xfer(addr, 32'h0, 4'h0, data, acc);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b1;
    bus.iomem_valid = 1'b0; bus.iomem_wstrb = 4'h0;
    bus.iomem_addr = 32'h0; bus.iomem_wdata = 32'h0;
    wait_cycles(3);
    checks++;
    if (ws_write !== 1'b0 || ws_led_num !== 8'h0 || ws_rgb_data !== 24'h0) begin
      errors++;
      $display("FAIL reset_ws: got write=%b led=%h rgb=%h, required 0/00/000000",
               ws_write, ws_led_num, ws_rgb_data);
    end
    checks++;
    if (bus.iomem_ready !== 1'b0 || bus.iomem_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_bus: got ready=%b rdata=%h, required 0/00000000",
               bus.iomem_ready, bus.iomem_rdata);
    end
    reset = 1'b0;
    bright_m = 255;
    wait_cycles(1);
    rd(A_STATUS, d);
    checks++;
    if (d !== 32'h0) begin
      errors++; $display("FAIL reset_status: got %h, required 00000000", d);
    end
    rd(A_BRIGHT, d);
    checks++;
    if (d !== 32'h0000_00FF) begin
      errors++; $display("FAIL reset_bright: got %h, required 000000ff", d);
    end
  endtask

  task automatic test_pixel();
    int acc, cnt;
    logic [31:0] d;
    obs.delete(); exp_q.delete();
    wr(A_PIXEL, 32'h0212_3456, acc);
    exp_q.push_back(mk_ev(acc, 2, 24'h123456));
    wait_cycles(1);
    checks++;
    if (bus.iomem_ready !== 1'b0) begin
      errors++; $display("FAIL pixel_ready_width: ready=%b one cycle after ack, required 0", bus.iomem_ready);
    end
    wr(A_PIXEL, 32'h08AB_CDEF, acc);
    // Out-of-window request must never be acknowledged.
    bus.iomem_valid = 1'b1; bus.iomem_addr = 32'h0300_0010;
    bus.iomem_wstrb = 4'hF; bus.iomem_wdata = 32'h0011_2233;
    cnt = 0;
    repeat (4) begin @(posedge clk); #1; if (bus.iomem_ready === 1'b1) cnt++; end
    bus.iomem_valid = 1'b0; bus.iomem_wstrb = 4'h0;
    checks++;
    if (cnt != 0) begin
      errors++; $display("FAIL out_of_window: got %0d acks, required 0", cnt);
    end
    // Randomised brightness and pixels, including out-of-range indices.
    for (int i = 0; i < 10; i++) begin
      int b, idx;
      logic [23:0] col;
      b = int'($urandom_range(0, 255));
      idx = int'($urandom_range(0, 9));
      col = 24'($urandom);
      wr(A_BRIGHT, 32'hABCD_EF00 | 32'(b), acc);
      bright_m = b;
      rd(A_BRIGHT, d);
      checks++;
      if (d !== 32'(b)) begin
        errors++; $display("FAIL bright_readback: got %h, required %h", d, 32'(b));
      end
      wr(A_PIXEL, {8'(idx), col}, acc);
      if (idx < int'(NUM_LEDS)) exp_q.push_back(mk_ev(acc, idx, scale_ref(col, b)));
    end
    wait_cycles(2);
    checks++;
    if (obs.size() != exp_q.size()) begin
      errors++; $display("FAIL pixel_count: got %0d pulses, required %0d", obs.size(), exp_q.size());
    end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs[i].t != exp_q[i].t || obs[i].idx !== exp_q[i].idx || obs[i].rgb !== exp_q[i].rgb) begin
        errors++;
        $display("FAIL pixel_ev%0d: got t=%0d led=%0d rgb=%h, required t=%0d led=%0d rgb=%h", i,
                 obs[i].t, obs[i].idx, obs[i].rgb, exp_q[i].t, exp_q[i].idx, exp_q[i].rgb);
      end
    end
  endtask

  task automatic test_fill();
    int f, r;
    logic [31:0] d, e;
    obs.delete(); exp_q.delete();
    wr(A_FILL, 32'hFF00_FF00, f);
    for (int k = 0; k < int'(NUM_LEDS); k++)
      exp_q.push_back(mk_ev(f + 1 + k, k, scale_ref(24'h00FF00, bright_m)));
    bus_xfer(A_STATUS, 32'h0, 4'h0, d, r);
    // STATUS is sampled at its accept edge: fill_idx counts pixels issued by then.
    e = {23'b0, 1'b1, 8'(r - 1 - f)};
    checks++;
    if (d !== e) begin
      errors++; $display("FAIL fill_status_busy: got %h, required %h", d, e);
    end
    wait_cycles(NUM_LEDS + 2);
    rd(A_STATUS, d);
    checks++;
    if (d !== 32'(NUM_LEDS)) begin
      errors++; $display("FAIL fill_status_done: got %h, required %h", d, 32'(NUM_LEDS));
    end
    checks++;
    if (obs.size() != exp_q.size()) begin
      errors++; $display("FAIL fill_count: got %0d pulses, required %0d", obs.size(), exp_q.size());
    end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs[i].t != exp_q[i].t || obs[i].idx !== exp_q[i].idx || obs[i].rgb !== exp_q[i].rgb) begin
        errors++;
        $display("FAIL fill_ev%0d: got t=%0d led=%0d rgb=%h, required t=%0d led=%0d rgb=%h", i,
                 obs[i].t, obs[i].idx, obs[i].rgb, exp_q[i].t, exp_q[i].idx, exp_q[i].rgb);
      end
    end
  endtask

  task automatic test_contention();
    int f, p, t, k;
    logic [23:0] col;
    obs.delete(); exp_q.delete();
    col = 24'($urandom);
    wr(A_FILL, {8'h0, col}, f);
    wait_cycles(3);
    wr(A_PIXEL, 32'h0500_00FF, p);
    // Fill pixels occupy successive free slots; the CPU pixel takes its own slot.
    t = f + 1; k = 0;
    while (k < int'(NUM_LEDS)) begin
      if (t == p) exp_q.push_back(mk_ev(t, 5, scale_ref(24'h0000FF, bright_m)));
      else begin exp_q.push_back(mk_ev(t, k, scale_ref(col, bright_m))); k++; end
      t++;
    end
    wait_cycles(NUM_LEDS + 4);
    checks++;
    if (obs.size() != NUM_LEDS + 1) begin
      errors++; $display("FAIL contention_count: got %0d pulses, required %0d", obs.size(), NUM_LEDS + 1);
    end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs[i].t != exp_q[i].t || obs[i].idx !== exp_q[i].idx || obs[i].rgb !== exp_q[i].rgb) begin
        errors++;
        $display("FAIL contention_ev%0d: got t=%0d led=%0d rgb=%h, required t=%0d led=%0d rgb=%h", i,
                 obs[i].t, obs[i].idx, obs[i].rgb, exp_q[i].t, exp_q[i].idx, exp_q[i].rgb);
      end
    end
  endtask

  task automatic test_brightness();
    int acc;
    obs.delete();
    wr(A_BRIGHT, 32'd127, acc);
    bright_m = 127;
    wr(A_PIXEL, 32'h00FF_8001, acc);
    wr(A_BRIGHT, 32'd0, acc);
    bright_m = 0;
    wr(A_PIXEL, 32'h03FF_FFFF, acc);
    wait_cycles(2);
    checks++;
    if (obs.size() != 2) begin
      errors++; $display("FAIL bright_count: got %0d pulses, required 2", obs.size());
    end else begin
      checks++;
      if (obs[0].idx !== 8'd0 || obs[0].rgb !== 24'h7F4000) begin
        errors++; $display("FAIL bright_127: got led=%0d rgb=%h, required led=0 rgb=7f4000", obs[0].idx, obs[0].rgb);
      end
      checks++;
      if (obs[1].idx !== 8'd3 || obs[1].rgb !== 24'h000000) begin
        errors++; $display("FAIL bright_0: got led=%0d rgb=%h, required led=3 rgb=000000", obs[1].idx, obs[1].rgb);
      end
    end
  endtask

  task automatic test_restart();
    int acc, f1, f2, k, nb;
    logic [23:0] ca, cb;
    wr(A_BRIGHT, 32'd200, acc);
    bright_m = 200;
    ca = 24'h0A0B0C; cb = 24'hC0B0A0;
    obs.delete();
    wr(A_FILL, {8'h0, ca}, f1);
    wait_cycles(2);
    wr(A_FILL, {8'h0, cb}, f2);
    wait_cycles(NUM_LEDS + 4);
    k = 0; nb = 0;
    foreach (obs[i]) begin
      if (obs[i].t <= f2) begin
        checks++;
        if (obs[i].t != f1 + 1 + k || obs[i].idx !== 8'(k) || obs[i].rgb !== scale_ref(ca, bright_m)) begin
          errors++;
          $display("FAIL restart_old%0d: got t=%0d led=%0d rgb=%h, required t=%0d led=%0d rgb=%h", k,
                   obs[i].t, obs[i].idx, obs[i].rgb, f1 + 1 + k, k, scale_ref(ca, bright_m));
        end
        k++;
      end else begin
        checks++;
        if (obs[i].t != f2 + 1 + nb || obs[i].idx !== 8'(nb) || obs[i].rgb !== scale_ref(cb, bright_m)) begin
          errors++;
          $display("FAIL restart_new%0d: got t=%0d led=%0d rgb=%h, required t=%0d led=%0d rgb=%h", nb,
                   obs[i].t, obs[i].idx, obs[i].rgb, f2 + 1 + nb, nb, scale_ref(cb, bright_m));
        end
        nb++;
      end
    end
    checks++;
    if (k < 2 || nb != int'(NUM_LEDS)) begin
      errors++; $display("FAIL restart_count: got old=%0d new=%0d, required old>=2 new=%0d", k, nb, NUM_LEDS);
    end
  endtask

  task automatic test_reset_midfill();
    int acc, f, r, late;
    logic [31:0] d;
    wr(A_BRIGHT, 32'h40, acc);
    obs.delete();
    wr(A_FILL, 32'h0012_3456, f);
    wait_cycles(3);
    reset = 1'b1;
    @(posedge clk); #1;
    r = cyc;
    reset = 1'b0;
    bright_m = 255;
    wait_cycles(NUM_LEDS + 4);
    late = 0;
    foreach (obs[i]) if (obs[i].t >= r) late++;
    checks++;
    if (late != 0) begin
      errors++; $display("FAIL reset_midfill_writes: got %0d pulses after reset, required 0", late);
    end
    rd(A_STATUS, d);
    checks++;
    if (d !== 32'h0) begin
      errors++; $display("FAIL reset_midfill_status: got %h, required 00000000", d);
    end
    rd(A_BRIGHT, d);
    checks++;
    if (d !== 32'h0000_00FF) begin
      errors++; $display("FAIL reset_midfill_bright: got %h, required 000000ff", d);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_pixel();
    test_fill();
    test_contention();
    test_brightness();
    test_restart();
    test_reset_midfill();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
